mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

- Multiply/divide unit sequencer for the five-stage pipeline: accepts one HI/LO operation per start from the E stage and runs it for a fixed multi-cycle latency.
- Holds the architectural HI/LO registers.
- Drives `Busy` to the hazard unit, which stalls any HI/LO instruction in E while `Start` or `Busy` is high.
- Start is suppressed on exception/interrupt via `Cancel`.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: occupancy of MULT/MULTU (and MADD family), ≥1.
- `DIV_CYCLES`, default 10: occupancy of DIV/DIVU, ≥1.

Ports:
- `Clk` in 1: the only clock.
- `Reset` in 1: asynchronous, active-low reset.
- `Start` in 1: E-stage HI/LO op valid this cycle.
- `Op` in 4: operation code. 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; other values behave as NOP.
- `A` in 32: rs value (already forwarded).
- `B` in 32: rt value (already forwarded).
- `Cancel` in 1: exception/eret flush this cycle. Masks `Start`; does not abort an op in flight.
- `Busy` out 1: operation in progress.
- `Done` out 1: one-cycle pulse after HI/LO commit of a timed op.
- `HI` out 32: HI register.
- `LO` out 32: LO register.

## Operation
- Accepted start: `Start && !Cancel && !Busy`. `Start` while `Busy` is ignored (the hazard unit guarantees it never happens).
- MTHI/MTLO: `A` is written to HI/LO at the accepting edge. No `Busy`, no `Done`.
- Timed ops (MULT family, DIV family) at the accepting edge:
  - latch `Op`, `A`, `B`;
  - load the down-counter with N−1 (N = `MULT_CYCLES` or `DIV_CYCLES`);
  - enter RUN.
- State machine:
  - IDLE → RUN on an accepted timed op.
  - RUN: the counter decrements each edge. At the edge where the counter is 0, commit HI/LO, go to IDLE, set `Done` for the next cycle.
- Arithmetic, on the latched operands:
  - MULT: 64-bit signed product; MULTU: unsigned. {HI,LO} = product.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
  - Divide by zero: HI/LO unchanged; `Busy` and `Done` still follow the normal timing.
  - MADD/MADDU: {HI,LO} += product, mod 2^64. MSUB/MSUBU: {HI,LO} −= product, mod 2^64. HI/LO are sampled at commit time.
- Reset asserted at any time, including mid-RUN: IDLE, counter 0, HI = LO = 0, `Busy` = 0, `Done` = 0, immediately and asynchronously. The in-flight result is lost.

## Timing
- Reset values of all outputs: `Busy` 0, `Done` 0, `HI` 0, `LO` 0.
- Timed op accepted at the edge ending cycle t:
  - `Busy` = 1 in cycles t+1 … t+N.
  - HI/LO show the new value in cycle t+N+1.
  - `Done` = 1 in cycle t+N+1 only; `Busy` = 0 there.
- Back-to-back: a new `Start` is accepted in cycle t+N+1. It sees the committed HI/LO, so no extra bubble is needed.
- MTHI/MTLO accepted at the edge ending cycle t: visible in cycle t+1.
- `Cancel` with `Start` in the same cycle: no state change.
- `Cancel` during RUN: ignored; the op completes and commits.
- MFHI/MFLO read `HI`/`LO` combinationally. While `Busy`, the hazard unit stalls them.

## Configuration
- Macro `MDU_MADD_EN`.
- Defined: ops 7–10 are implemented as above.
- Undefined:
  - ops 7–10 are treated as NOP (not accepted, no `Busy`);
  - the 64-bit accumulate adder is not synthesised.

## Structure
- Shared package `mdu_pkg`:
  - op-code constants (`MDU_NOP` … `MDU_MSUBU`);
  - state encoding `MDU_IDLE`/`MDU_RUN`;
  - default cycle constants.
- One sub-module, `mdu_alu`: purely combinational 64-bit result from latched op/operands/current HI/LO. It is instantiated once; `mdu_ctrl` owns the state, counter and registers.

## Test plan
- MULT A=0xFFFFFFFE (−2), B=3 at cycle 0 → `Busy` cycles 1–5; cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFA, `Done`=1.
- DIV A=7, B=0xFFFFFFFE (−2) → `Busy` cycles 1–10; then LO=0xFFFFFFFD, HI=1. Follow with DIVU A=5, B=0 → HI/LO unchanged, `Done` still pulses at +11.
- MTLO A=0x1234 with `Cancel`=1 → LO unchanged. Repeat with `Cancel`=0 → LO=0x1234 next cycle, `Busy` never high.
- MULTU 0xFFFFFFFF×0xFFFFFFFF, then `Reset` pulled low in cycle 3 → `Busy`/HI/LO = 0 immediately; after release, IDLE and a new MTHI is accepted.
- Under `MDU_MADD_EN`:
  - HI=0, LO=0xFFFFFFFF, MADDU 1×1 → HI=1, LO=0;
  - MSUB 1×1 from {0,0} → HI=LO=0xFFFFFFFF.
- Without the macro: the same op gives no `Busy`, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: MDU op codes, FSM encoding, latency defaults and op classification.
// MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU accumulate ops to the timed set.
package mdu_pkg;
   localparam logic [3:0] MDU_NOP   = 4'd0,
                          MDU_MULT  = 4'd1,
                          MDU_MULTU = 4'd2,
                          MDU_DIV   = 4'd3,
                          MDU_DIVU  = 4'd4,
                          MDU_MTHI  = 4'd5,
                          MDU_MTLO  = 4'd6,
                          MDU_MADD  = 4'd7,
                          MDU_MADDU = 4'd8,
                          MDU_MSUB  = 4'd9,
                          MDU_MSUBU = 4'd10;
   localparam logic [0:0] MDU_IDLE = 1'b0,
                          MDU_RUN  = 1'b1;
   localparam int MDU_MULT_CYCLES = 5;
   localparam int MDU_DIV_CYCLES  = 10;
   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } mdu_cmd_t;
   function automatic logic mdu_is_div(input logic [3:0] op);
      return op == MDU_DIV || op == MDU_DIVU;
   endfunction
   function automatic logic mdu_is_timed(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return (op >= MDU_MULT && op <= MDU_DIVU) || (op >= MDU_MADD && op <= MDU_MSUBU);
`else
      return op >= MDU_MULT && op <= MDU_DIVU;
`endif
   endfunction
endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E-stage request and HI/LO result bundle of the MDU sequencer.
interface mdu_ctrl_if;
   logic        Start;
   logic        Cancel;
   logic [3:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic        Done;
   logic [31:0] HI;
   logic [31:0] LO;
   modport master (output Start, Cancel, Op, A, B, input Busy, Done, HI, LO);
   modport slave  (input Start, Cancel, Op, A, B, output Busy, Done, HI, LO);
endinterface

// File: rtl/mdu_alu.sv
// mdu_alu: combinational 64-bit {HI,LO} result of a latched MDU command.
// MDU_MADD_EN adds the 64-bit accumulate adder for MADD/MSUB.
module mdu_alu import mdu_pkg::*; (
   input  mdu_cmd_t    cmd_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   output logic [63:0] res_o
);
   logic [63:0] hilo, prod_s, prod_u, prod;
   logic [31:0] mag_a, mag_b, div_b, quo_u, rem_u, quo, rem;
   logic        sgn, div_zero;
   assign hilo     = {hi_i, lo_i};
   assign sgn      = cmd_i.op == MDU_MULT || cmd_i.op == MDU_DIV ||
                     cmd_i.op == MDU_MADD || cmd_i.op == MDU_MSUB;
   assign prod_s   = {{32{cmd_i.a[31]}}, cmd_i.a} * {{32{cmd_i.b[31]}}, cmd_i.b};
   assign prod_u   = {32'b0, cmd_i.a} * {32'b0, cmd_i.b};
   assign prod     = sgn ? prod_s : prod_u;
   // Sign-magnitude division also yields 0x80000000 for the -2^31 / -1 overflow case.
   assign mag_a    = sgn && cmd_i.a[31] ? -cmd_i.a : cmd_i.a;
   assign mag_b    = sgn && cmd_i.b[31] ? -cmd_i.b : cmd_i.b;
   assign div_zero = cmd_i.b == '0;
   assign div_b    = div_zero ? 32'd1 : mag_b;
   assign quo_u    = mag_a / div_b;
   assign rem_u    = mag_a % div_b;
   assign quo      = sgn && (cmd_i.a[31] ^ cmd_i.b[31]) ? -quo_u : quo_u;
   assign rem      = sgn && cmd_i.a[31] ? -rem_u : rem_u;
`ifdef MDU_MADD_EN
   logic [63:0] acc;
   assign acc   = cmd_i.op == MDU_MSUB || cmd_i.op == MDU_MSUBU ? hilo - prod : hilo + prod;
   assign res_o = mdu_is_div(cmd_i.op) ? (div_zero ? hilo : {rem, quo}) :
                  cmd_i.op >= MDU_MADD ? acc : prod;
`else
   assign res_o = mdu_is_div(cmd_i.op) ? (div_zero ? hilo : {rem, quo}) : prod;
`endif
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle HI/LO sequencer holding the architectural HI/LO registers.
// MDU_MADD_EN enables the MADD/MSUB family (see mdu_pkg).
module mdu_ctrl import mdu_pkg::*; #(
   parameter int MULT_CYCLES = MDU_MULT_CYCLES,
   parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
   input logic       Clk,
   input logic       Reset,
   mdu_ctrl_if.slave bus
);
   localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   mdu_cmd_t      cmd_q, cmd_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic          done_q;
   logic [63:0]   res;
   logic          accept, launch, commit;
   assign accept = bus.Start && !bus.Cancel && state_q == MDU_IDLE;
   assign launch = accept && mdu_is_timed(bus.Op);
   assign commit = state_q == MDU_RUN && cnt_q == '0;
   mdu_alu u_alu (.cmd_i(cmd_q), .hi_i(hi_q), .lo_i(lo_q), .res_o(res));
   always_comb begin
      state_d = commit ? MDU_IDLE : launch ? MDU_RUN : state_q;
      cnt_d   = launch ? (mdu_is_div(bus.Op) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1)) :
                state_q == MDU_RUN && !commit ? cnt_q - CW'(1) : cnt_q;
      cmd_d   = launch ? {bus.Op, bus.A, bus.B} : cmd_q;
      hi_d    = commit ? res[63:32] : accept && bus.Op == MDU_MTHI ? bus.A : hi_q;
      lo_d    = commit ? res[31:0]  : accept && bus.Op == MDU_MTLO ? bus.A : lo_q;
   end
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= MDU_IDLE;
         cnt_q   <= '0;
         cmd_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= commit;
      end
   end
   assign bus.Busy = state_q == MDU_RUN;
   assign bus.Done = done_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vector table plus hand sequences for mdu_ctrl.
// Expected values for ops 7-10 depend on MDU_MADD_EN.
module tb_mdu_ctrl;
   import mdu_pkg::*;
   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        cancel;
      int          n;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;
   logic Clk = 1'b0;
   logic Reset = 1'b0;
   int n_run = 0;
   int n_fail = 0;
   vec_t vt[24];
   int nv = 0;
   mdu_ctrl_if bus();
   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge Clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic cancel);
      bus.Start = 1'b1;
      bus.Op = op;
      bus.A = a;
      bus.B = b;
      bus.Cancel = cancel;
      step();
      bus.Start = 1'b0;
      bus.Cancel = 1'b0;
   endtask

   task automatic add(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic cancel,
                      input int n, input logic [31:0] hi, input logic [31:0] lo);
      vt[nv] = '{op, a, b, cancel, n, hi, lo};
      nv++;
   endtask

   task automatic run_vec(input int i);
      logic [31:0] bp, dp;
      logic [63:0] hl;
      bp = '0;
      dp = '0;
      hl = '0;
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].cancel);
      for (int k = 1; k <= vt[i].n + 2; k++) begin
         bp[k] = bus.Busy;
         dp[k] = bus.Done;
         if (k == vt[i].n + 1) hl = {bus.HI, bus.LO};
         step();
      end
      check($sformatf("v%0d busy", i), {32'b0, bp}, {32'b0, ((32'h1 << vt[i].n) - 32'h1) << 1});
      check($sformatf("v%0d done", i), {32'b0, dp}, vt[i].n > 0 ? 64'h1 << (vt[i].n + 1) : 64'h0);
      check($sformatf("v%0d hilo", i), hl, {vt[i].hi, vt[i].lo});
   endtask

   initial begin
      bus.Start = 1'b0;
      bus.Cancel = 1'b0;
      bus.Op = MDU_NOP;
      bus.A = '0;
      bus.B = '0;
      add(MDU_MULT,  32'hFFFFFFFE, 32'h3,        0, 5,  32'hFFFFFFFF, 32'hFFFFFFFA);
      add(MDU_DIV,   32'h7,        32'hFFFFFFFE, 0, 10, 32'h1,        32'hFFFFFFFD);
      add(MDU_DIVU,  32'h5,        32'h0,        0, 10, 32'h1,        32'hFFFFFFFD);
      add(MDU_MTLO,  32'h1234,     32'h0,        1, 0,  32'h1,        32'hFFFFFFFD);
      add(MDU_MTLO,  32'h1234,     32'h0,        0, 0,  32'h1,        32'h1234);
      add(MDU_MTHI,  32'hDEADBEEF, 32'h0,        0, 0,  32'hDEADBEEF, 32'h1234);
      add(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 5,  32'hFFFFFFFE, 32'h00000001);
      add(MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 10, 32'h0,        32'h80000000);
      add(MDU_DIV,   32'hFFFFFFF9, 32'h2,        0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
      add(MDU_DIVU,  32'hFFFFFFFF, 32'h10,       0, 10, 32'hF,        32'h0FFFFFFF);
      add(MDU_NOP,   32'h1,        32'h1,        0, 0,  32'hF,        32'h0FFFFFFF);
      add(4'd15,     32'h1,        32'h1,        0, 0,  32'hF,        32'h0FFFFFFF);
      add(MDU_MULT,  32'h2,        32'h2,        1, 0,  32'hF,        32'h0FFFFFFF);
      add(MDU_MTHI,  32'h0,        32'h0,        0, 0,  32'h0,        32'h0FFFFFFF);
      add(MDU_MTLO,  32'hFFFFFFFF, 32'h0,        0, 0,  32'h0,        32'hFFFFFFFF);
`ifdef MDU_MADD_EN
      add(MDU_MADDU, 32'h1,        32'h1,        0, 5,  32'h1,        32'h0);
      add(MDU_MTHI,  32'h0,        32'h0,        0, 0,  32'h0,        32'h0);
      add(MDU_MTLO,  32'h0,        32'h0,        0, 0,  32'h0,        32'h0);
      add(MDU_MSUB,  32'h1,        32'h1,        0, 5,  32'hFFFFFFFF, 32'hFFFFFFFF);
      add(MDU_MADD,  32'hFFFFFFFF, 32'h2,        0, 5,  32'hFFFFFFFF, 32'hFFFFFFFD);
      add(MDU_MSUBU, 32'h2,        32'h3,        0, 5,  32'hFFFFFFFF, 32'hFFFFFFF7);
`else
      add(MDU_MADDU, 32'h1,        32'h1,        0, 0,  32'h0,        32'hFFFFFFFF);
      add(MDU_MTHI,  32'h0,        32'h0,        0, 0,  32'h0,        32'hFFFFFFFF);
      add(MDU_MTLO,  32'h0,        32'h0,        0, 0,  32'h0,        32'h0);
      add(MDU_MSUB,  32'h1,        32'h1,        0, 0,  32'h0,        32'h0);
      add(MDU_MADD,  32'hFFFFFFFF, 32'h2,        0, 0,  32'h0,        32'h0);
      add(MDU_MSUBU, 32'h2,        32'h3,        0, 0,  32'h0,        32'h0);
`endif
      step();
      check("reset busy/done", {62'b0, bus.Busy, bus.Done}, 64'h0);
      check("reset hilo", {bus.HI, bus.LO}, 64'h0);
      Reset = 1'b1;
      step();
      for (int i = 0; i < nv; i++) run_vec(i);
      // back-to-back: second MULT issued in the Done cycle of the first
      issue(MDU_MULT, 32'h2, 32'h3, 0);
      for (int k = 0; k < 5; k++) step();
      check("b2b done1", {63'b0, bus.Done}, 64'h1);
      check("b2b hilo1", {bus.HI, bus.LO}, 64'h6);
      issue(MDU_MULT, 32'h4, 32'h5, 0);
      check("b2b busy2", {63'b0, bus.Busy}, 64'h1);
      for (int k = 0; k < 5; k++) step();
      check("b2b done2", {63'b0, bus.Done}, 64'h1);
      check("b2b hilo2", {bus.HI, bus.LO}, 64'd20);
      // Cancel and a stray MTHI during RUN must not disturb the op in flight
      issue(MDU_MULT, 32'h3, 32'h3, 0);
      bus.Cancel = 1'b1;
      step();
      bus.Cancel = 1'b0;
      bus.Start = 1'b1;
      bus.Op = MDU_MTHI;
      bus.A = 32'hAAAA;
      step();
      bus.Start = 1'b0;
      step();
      step();
      check("run busy", {63'b0, bus.Busy}, 64'h1);
      check("run hilo held", {bus.HI, bus.LO}, 64'd20);
      step();
      check("run done", {62'b0, bus.Busy, bus.Done}, 64'h1);
      check("run hilo", {bus.HI, bus.LO}, 64'd9);
      step();
      // asynchronous reset in cycle 3 of a MULTU
      issue(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      step();
      step();
      check("pre-reset busy", {63'b0, bus.Busy}, 64'h1);
      #2 Reset = 1'b0;
      #1;
      check("async reset busy/done", {62'b0, bus.Busy, bus.Done}, 64'h0);
      check("async reset hilo", {bus.HI, bus.LO}, 64'h0);
      step();
      Reset = 1'b1;
      step();
      for (int k = 0; k < 8; k++) begin
         check($sformatf("post-reset idle %0d", k), {62'b0, bus.Busy, bus.Done}, 64'h0);
         step();
      end
      issue(MDU_MTHI, 32'h55, 32'h0, 0);
      check("post-reset mthi", {bus.HI, bus.LO}, {32'h55, 32'h0});
      check("post-reset mthi busy", {63'b0, bus.Busy}, 64'h0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
